// File: rtl/alu_mc_param_if.sv
// Request/response bundle for the multi-cycle ALU: operands and opcode in,
// registered result, flags and status out.
interface alu_mc_param_if #(parameter int W = 4);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [1:0]     ctrl;
  logic [2*W-1:0] y;
  logic           c;
  logic           err;
  logic           busy;
  logic           done;

  modport master (output start, a, b, ctrl, input y, c, err, busy, done);
  modport slave  (input start, a, b, ctrl, output y, c, err, busy, done);
endinterface

// File: rtl/alu_mc_param.sv
// Multi-cycle ALU: single-cycle ADD/SUB, W-iteration shift-add MUL and
// restoring DIV, with a one-cycle done pulse and registered result.
module alu_mc_param #(
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_mc_param_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         st, st_nxt;
  logic           run_div;
  logic [W-1:0]   cnt, mplier, divisor;
  logic [2*W-1:0] mcand, acc;
  logic [W:0]     sum, dif, rem_sh;
  logic [W-1:0]   rem_new;
  logic           ge;
  logic [2*W-1:0] mul_nxt, div_nxt;
  logic           accept, last, divz;

  assign accept = (st == IDLE) && bus.start;
  assign last   = (st == RUN) && (cnt == W'(1));
  assign divz   = (bus.ctrl == 2'b11) && (bus.b == '0);
  assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
  assign dif    = {1'b0, bus.a} - {1'b0, bus.b};

  // MUL step: acc holds the partial product, mcand the shifted multiplicand.
  assign mul_nxt = mplier[0] ? acc + mcand : acc;

  // DIV step: acc = {remainder, dividend/quotient}; shift one dividend bit in.
  assign rem_sh  = acc[2*W-1:W-1];
  assign ge      = rem_sh >= {1'b0, divisor};
  assign rem_new = ge ? W'(rem_sh - {1'b0, divisor}) : rem_sh[W-1:0];
  assign div_nxt = {rem_new, acc[W-2:0], ge};

  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: if (bus.start) st_nxt = (bus.ctrl[1] && !divz) ? RUN : DONE;
      RUN:  if (last) st_nxt = DONE;
      DONE: st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (st != IDLE);
    bus.done = (st == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_div <= 1'b0;
      cnt     <= '0;
      mplier  <= '0;
      divisor <= '0;
      mcand   <= '0;
      acc     <= '0;
      bus.y   <= '0;
      bus.c   <= 1'b0;
      bus.err <= 1'b0;
    end else if (accept) begin
      run_div <= bus.ctrl[0];
      cnt     <= W'(W);
      case (bus.ctrl)
        2'b00: begin
          bus.y   <= {{W{1'b0}}, sum[W-1:0]};
          bus.c   <= sum[W];
          bus.err <= 1'b0;
        end
        2'b01: begin
          bus.y   <= {{W{1'b0}}, dif[W-1:0]};
          bus.c   <= dif[W];
          bus.err <= 1'b0;
        end
        2'b10: begin
          acc    <= '0;
          mcand  <= {{W{1'b0}}, bus.a};
          mplier <= bus.b;
        end
        default: begin
          if (divz) begin
            bus.y   <= '0;
            bus.c   <= 1'b0;
            bus.err <= 1'b1;
          end else begin
            acc     <= {{W{1'b0}}, bus.a};
            divisor <= bus.b;
          end
        end
      endcase
    end else if (st == RUN) begin
      cnt <= cnt - W'(1);
      if (run_div) begin
        acc <= div_nxt;
      end else begin
        acc    <= mul_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      // Only the final step is published; partial values never reach y.
      if (last) begin
        bus.y   <= run_div ? div_nxt : mul_nxt;
        bus.c   <= 1'b0;
        bus.err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc_param.sv
// Scoreboard bench for alu_mc_param (W=4): directed vectors push expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_alu_mc_param;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  alu_mc_param_if #(.W(W)) bus();
  alu_mc_param #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string          tag;
    logic [2*W-1:0] y;
    logic           c;
    logic           err;
    int             at;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, expected no pending result", cyc);
      end else begin
        me = q.pop_front();
        check({me.tag, ".y"},   32'(bus.y),   32'(me.y));
        check({me.tag, ".c"},   32'(bus.c),   32'(me.c));
        check({me.tag, ".err"}, 32'(bus.err), 32'(me.err));
        check({me.tag, ".cyc"}, 32'(cyc),     32'(me.at));
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] z);
    bus.ctrl = op;
    bus.a    = x;
    bus.b    = z;
  endtask

  // Called at the negedge where start is raised; acceptance is the next edge.
  task automatic expect_res(input string tag, input logic [2*W-1:0] y, input logic c,
                            input logic err, input int lat);
    exp_t e;
    e.tag = tag; e.y = y; e.c = c; e.err = err; e.at = cyc + 1 + lat;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_timeout: got busy=1 after 50 cycles, expected 0");
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] x,
                     input logic [W-1:0] z, input logic [2*W-1:0] y, input logic c,
                     input logic err, input int lat);
    wait_idle();
    drive(op, x, z);
    bus.start = 1'b1;
    expect_res(tag, y, c, err, lat);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    wait_idle();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    drive(2'b00, '0, '0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.y",    32'(bus.y),    32'd0);
    check("rst.c",    32'(bus.c),    32'd0);
    check("rst.err",  32'(bus.err),  32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);

    // First start right as reset drops must be taken on the next edge.
    reset = 1'b0;
    run("add9_8",   2'b00, 4'd9,  4'd8, 8'h01, 1'b1, 1'b0, 0);
    run("sub3_5",   2'b01, 4'd3,  4'd5, 8'h0E, 1'b1, 1'b0, 0);
    run("sub5_3",   2'b01, 4'd5,  4'd3, 8'h02, 1'b0, 1'b0, 0);
    run("add15_15", 2'b00, 4'd15, 4'd15, 8'h0E, 1'b1, 1'b0, 0);
    run("sub0_0",   2'b01, 4'd0,  4'd0, 8'h00, 1'b0, 1'b0, 0);

    // MUL 15*15 with operands scrambled during RUN.
    wait_idle();
    drive(2'b10, 4'd15, 4'd15);
    bus.start = 1'b1;
    expect_res("mul15_15", 8'hE1, 1'b0, 1'b0, W);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("mul15_15.busy_run", 32'(bus.busy), 32'd1);
      bus.a = ~bus.a;
      bus.b = 4'(i);
      @(negedge clk);
    end
    check("mul15_15.busy_done", 32'(bus.busy), 32'd1);
    wait_idle();
    @(negedge clk);

    run("mul0_7",   2'b10, 4'd0,  4'd7,  8'h00, 1'b0, 1'b0, W);
    run("mul1_15",  2'b10, 4'd1,  4'd15, 8'h0F, 1'b0, 1'b0, W);
    run("mul12_10", 2'b10, 4'd12, 4'd10, 8'h78, 1'b0, 1'b0, W);
    run("div13_4",  2'b11, 4'd13, 4'd4,  8'h13, 1'b0, 1'b0, W);
    run("div10_0",  2'b11, 4'd10, 4'd0,  8'h00, 1'b0, 1'b1, 0);
    run("div15_1",  2'b11, 4'd15, 4'd1,  8'h0F, 1'b0, 1'b0, W);
    run("div3_7",   2'b11, 4'd3,  4'd7,  8'h30, 1'b0, 1'b0, W);
    run("div14_3",  2'b11, 4'd14, 4'd3,  8'h24, 1'b0, 1'b0, W);

    // err must clear on the next good result.
    run("add_after_err", 2'b00, 4'd4, 4'd4, 8'h08, 1'b0, 1'b0, 0);

    // DIV pulsed at T+2 during MUL 3*5: only the MUL completes.
    wait_idle();
    drive(2'b10, 4'd3, 4'd5);
    bus.start = 1'b1;
    expect_res("mul3_5", 8'h0F, 1'b0, 1'b0, W);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    drive(2'b11, 4'd9, 4'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("ignore_run.idle", 32'(bus.busy), 32'd0);

    // start held into the DONE cycle of an ADD is dropped.
    drive(2'b00, 4'd4, 4'd5);
    bus.start = 1'b1;
    expect_res("add4_5", 8'h09, 1'b0, 1'b0, 0);
    @(negedge clk);
    drive(2'b11, 4'd8, 4'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("ignore_done.idle", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("ignore_done.err", 32'(bus.err), 32'd0);

    // start held high: back-to-back ADDs complete every 2 cycles.
    drive(2'b00, 4'd1, 4'd2);
    bus.start = 1'b1;
    expect_res("b2b0", 8'h03, 1'b0, 1'b0, 0);
    expect_res("b2b1", 8'h03, 1'b0, 1'b0, 2);
    expect_res("b2b2", 8'h03, 1'b0, 1'b0, 4);
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    @(negedge clk);

    // Reset at T+2 aborts a MUL: no done, outputs cleared.
    run("mul2_7", 2'b10, 4'd2, 4'd7, 8'h0E, 1'b0, 1'b0, W);
    drive(2'b10, 4'd15, 4'd15);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.y",    32'(bus.y),    32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort.no_done", 32'(bus.done), 32'd0);
    end
    run("add2_1", 2'b00, 4'd2, 4'd1, 8'h03, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_mc_param.md
ALU_MC_PARAM -- requirements
Module: alu_mc_param

Interface
REQ-001 Parameter: W, 4, operand width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: a  input  W  operand A, unsigned.
REQ-006 Port: b  input  W  operand B, unsigned.
REQ-007 Port: ctrl  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-008 Port: y  output  2W  result, registered.
REQ-009 Port: c  output  1  carry (ADD) / borrow (SUB), registered; 0 for MUL/DIV.
REQ-010 Port: err  output  1  divide-by-zero flag, registered.
REQ-011 Port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 Port: done  output  1  one-cycle pulse marking a valid result.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE; reset state is IDLE.
REQ-014 In IDLE with start=1 (acceptance edge T), a, b and ctrl SHALL be latched; later operand changes SHALL NOT affect the result.
REQ-015 ADD/SUB, and DIV with b=0: IDLE -> DONE at T; done=1 in cycle T+1; then DONE -> IDLE.
REQ-016 MUL/DIV with b!=0: IDLE -> RUN at T; exactly W iterations (one per clock) via a W-wide down-counter; then RUN -> DONE; done=1 in cycle T+W+1.
REQ-017 ADD: y[W-1:0] = (a+b) mod 2^W; y[2W-1:W] = 0; c = bit W of a+b.
REQ-018 SUB: y[W-1:0] = (a-b) mod 2^W; upper half 0; c = 1 iff a<b.
REQ-019 MUL: shift-add, LSB of multiplier first; y = a*b exact in 2W bits; c = 0.
REQ-020 DIV: restoring division, MSB first; y[W-1:0] = quotient; y[2W-1:W] = remainder; c = 0.
REQ-021 DIV with b=0: y = 0, c = 0, err = 1; no iterations are run.
REQ-022 err SHALL be 0 for every other result; err, y and c are written together in the cycle done rises.
REQ-023 y, c and err SHALL hold their values until the done of the next accepted operation; intermediate datapath values SHALL NOT appear on y.
REQ-024 start while busy=1, including the DONE cycle, SHALL be ignored with no queueing.
REQ-025 start held high continuously SHALL start a new operation on the first IDLE cycle after each done; back-to-back ADD gives done every 2 cycles.
REQ-026 busy=1 in RUN and DONE; busy=0 in IDLE, including the cycle the request is accepted.

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE, with y=0, c=0, err=0, done=0, busy=0, and the iteration counter and datapath registers at 0.
REQ-028 reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL never produce done.
REQ-029 After reset deasserts, the first start SHALL be accepted on the following edge.

Verification (W=4)
REQ-030 ADD a=9, b=8 -> done at T+1; y=0x01, c=1, err=0.
REQ-031 SUB a=3, b=5 -> done at T+1; y=0x0E, c=1; then SUB a=5, b=3 -> y=0x02, c=0.
REQ-032 MUL a=15, b=15 -> busy for cycles T+1..T+5; done at T+5; y=0xE1, c=0; a and b toggled during RUN leave the result unchanged.
REQ-033 DIV a=13, b=4 -> done at T+5; y=0x13 (quotient 3, remainder 1); DIV a=10, b=0 -> done at T+1, y=0x00, err=1.
REQ-034 MUL started, reset=1 at T+2 -> from T+3 busy=0, y=0, done stays 0 through T+8; a fresh ADD 2+1 then gives y=0x03.
REQ-035 start pulsed with a DIV at T+2 during a MUL run -> ignored; only the MUL done at T+5 occurs, then IDLE.
